// File: rtl/regbank_fwd.sv
// regbank_fwd: register file with write-through read ports, per-operand
// forwarding muxes, registered EX operands and a pending-write scoreboard.
// Ports: clk, rst_n (async, active low); ra/rb read addresses;
//   we/rw/wdata write-back; ans_ex/ans_dm/ans_wb forwarded results;
//   imm immediate; sel_a/sel_b (00 reg, 01 ex, 10 dm, 11 wb);
//   imm_sel (B = imm); hold freezes a/b and blocks issue;
//   issue_vld/issue_rd mark a destination pending; a/b operands;
//   hazard (comb) and pend_cnt (registered count of pending regs).
// Optional macro REGBANK_SCOREBOARD_EN enables the scoreboard;
// without it hazard and pend_cnt are tied 0 and issue is ignored.
module regbank_fwd #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 5,
  parameter int NREGS   = 32,
  parameter int R0_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  input  logic              we,
  input  logic [ADDR_W-1:0] rw,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] ans_ex,
  input  logic [DATA_W-1:0] ans_dm,
  input  logic [DATA_W-1:0] ans_wb,
  input  logic [DATA_W-1:0] imm,
  input  logic [1:0]        sel_a,
  input  logic [1:0]        sel_b,
  input  logic              imm_sel,
  input  logic              hold,
  input  logic              issue_vld,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic              hazard,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam logic [ADDR_W:0] NR = (ADDR_W+1)'(NREGS);
  localparam bit R0Z = (R0_ZERO != 0);

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] rd_a, rd_b;
  logic [DATA_W-1:0] mux_a, mux_b;
  logic              wr_ok;
  logic              go;

  function automatic logic in_rng(
    input logic [ADDR_W-1:0] x
  );
    return {1'b0, x} < NR;
  endfunction

  function automatic logic is_r0(
    input logic [ADDR_W-1:0] x
  );
    return R0Z && (x == '0);
  endfunction

  function automatic logic [DATA_W-1:0] fwd(
    input logic [1:0]        s,
    input logic [DATA_W-1:0] r,
    input logic [DATA_W-1:0] ex,
    input logic [DATA_W-1:0] dm,
    input logic [DATA_W-1:0] wb
  );
    logic [DATA_W-1:0] v;
    unique case (s)
      2'b00:   v = r;
      2'b01:   v = ex;
      2'b10:   v = dm;
      default: v = wb;
    endcase
    return v;
  endfunction

  assign wr_ok = we && in_rng(rw) && !is_r0(rw);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (wr_ok) begin
      regs[rw] <= wdata;
    end
  end

  // Same-cycle write-back is visible to the readers.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (in_rng(ra) && !is_r0(ra))
      rd_a = (wr_ok && rw == ra) ? wdata : regs[ra];
    if (in_rng(rb) && !is_r0(rb))
      rd_b = (wr_ok && rw == rb) ? wdata : regs[rb];
  end

  always_comb begin
    mux_a = fwd(sel_a, rd_a, ans_ex, ans_dm, ans_wb);
    mux_b = fwd(sel_b, rd_b, ans_ex, ans_dm, ans_wb);
    if (imm_sel)
      mux_b = imm;
  end

`ifdef REGBANK_SCOREBOARD_EN
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pend_nxt;
  logic [ADDR_W:0]  cnt_nxt;
  logic             pend_a, pend_b;
  logic             haz_a, haz_b;
  logic             issue_ok;

  always_comb begin
    pend_a = 1'b0;
    pend_b = 1'b0;
    if (in_rng(ra)) pend_a = pending[ra];
    if (in_rng(rb)) pend_b = pending[rb];
  end

  // A write-back landing this cycle covers the pending source.
  assign haz_a = (sel_a == 2'b00) && pend_a
              && !(we && rw == ra);
  assign haz_b = !imm_sel && (sel_b == 2'b00) && pend_b
              && !(we && rw == rb);
  assign hazard = haz_a | haz_b;

  assign issue_ok = issue_vld && !hold && !hazard
                 && in_rng(issue_rd) && !is_r0(issue_rd);

  // Set wins over a same-cycle clear of the same register.
  always_comb begin
    pend_nxt = pending;
    cnt_nxt  = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (we && rw == ADDR_W'(i))
        pend_nxt[i] = 1'b0;
      if (issue_ok && issue_rd == ADDR_W'(i))
        pend_nxt[i] = 1'b1;
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, pend_nxt[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      pending  <= pend_nxt;
      pend_cnt <= cnt_nxt;
    end
  end
`else
  logic unused_issue;

  assign unused_issue = ^{issue_vld, issue_rd};
  assign hazard   = 1'b0;
  assign pend_cnt = '0;
`endif

  assign go = !hold && !hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a <= '0;
      b <= '0;
    end else if (go) begin
      a <= mux_a;
      b <= mux_b;
    end
  end

endmodule

// File: tb/tb_regbank_fwd.sv
// tb_regbank_fwd: scenario tasks with a queue of expected operands.
// Hazard/pend_cnt expectations follow REGBANK_SCOREBOARD_EN.
module tb_regbank_fwd;

  localparam int DW = 16;
  localparam int AW = 5;
`ifdef REGBANK_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] ra, rb, rw, issue_rd;
  logic          we, imm_sel, hold, issue_vld;
  logic [DW-1:0] wdata, ans_ex, ans_dm, ans_wb, imm;
  logic [1:0]    sel_a, sel_b;
  logic [DW-1:0] a, b;
  logic          hazard;
  logic [AW:0]   pend_cnt;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  regbank_fwd #(
    .DATA_W(DW), .ADDR_W(AW),
    .NREGS(32), .R0_ZERO(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ra(ra), .rb(rb),
    .we(we), .rw(rw), .wdata(wdata),
    .ans_ex(ans_ex), .ans_dm(ans_dm),
    .ans_wb(ans_wb), .imm(imm),
    .sel_a(sel_a), .sel_b(sel_b),
    .imm_sel(imm_sel), .hold(hold),
    .issue_vld(issue_vld),
    .issue_rd(issue_rd),
    .a(a), .b(b),
    .hazard(hazard), .pend_cnt(pend_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ra = AW'($urandom); rb = AW'($urandom);
    rw = AW'($urandom); issue_rd = AW'($urandom);
    we = 1'b1; imm_sel = 1'b0; hold = 1'b0;
    issue_vld = 1'b1;
    wdata = DW'($urandom); imm = DW'($urandom);
    ans_ex = DW'($urandom); ans_dm = DW'($urandom);
    ans_wb = DW'($urandom);
    sel_a = 2'($urandom); sel_b = 2'($urandom);
    step();
    step();
    n_chk++;
    if (a !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_a got %h want 0000", a);
    end
    n_chk++;
    if (b !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_b got %h want 0000", b);
    end
    n_chk++;
    if (hazard !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_haz got %b want 0", hazard);
    end
    n_chk++;
    if (pend_cnt !== '0) begin
      n_fail++;
      $display("FAIL rst_cnt got %0d want 0", pend_cnt);
    end
    we = 1'b0; issue_vld = 1'b0;
    sel_a = 2'b00; sel_b = 2'b00;
    ans_ex = 16'hC000; ans_dm = 16'hD000;
    ans_wb = 16'hE000; imm = 16'hFFFF;
    rst_n = 1'b1;
    for (int i = 1; i < 32; i++) begin
      ra = AW'(i);
      rb = AW'(i);
      q.push_back('{a: 16'h0, b: 16'h0});
      step();
      e = q.pop_front();
      n_chk++;
      if (a !== e.a) begin
        n_fail++;
        $display("FAIL rst_rd_a r%0d got %h want %h",
                 i, a, e.a);
      end
      n_chk++;
      if (b !== e.b) begin
        n_fail++;
        $display("FAIL rst_rd_b r%0d got %h want %h",
                 i, b, e.b);
      end
    end
  endtask

  task automatic test_write();
    logic [DW-1:0] wd[3];
    logic          wv[3];
    logic [DW-1:0] xa[3];
    wd = '{16'h1234, 16'hABCD, 16'h0000};
    wv = '{1'b0, 1'b1, 1'b0};
    xa = '{16'h1234, 16'hABCD, 16'hABCD};
    we = 1'b1; rw = 5'd7; wdata = 16'h1234;
    ra = 5'd0; rb = 5'd0;
    step();
    ra = 5'd7;
    for (int i = 0; i < 3; i++) begin
      we = wv[i];
      wdata = wd[i];
      q.push_back('{a: xa[i], b: 16'h0});
      step();
      e = q.pop_front();
      n_chk++;
      if (a !== e.a) begin
        n_fail++;
        $display("FAIL write_rd%0d got %h want %h",
                 i, a, e.a);
      end
    end
    we = 1'b0;
  endtask

  task automatic test_r0();
    we = 1'b1; rw = 5'd0; wdata = 16'hFFFF;
    ra = 5'd0; sel_a = 2'b00;
    issue_vld = 1'b1; issue_rd = 5'd0;
    q.push_back('{a: 16'h0, b: 16'h0});
    step();
    we = 1'b0; issue_vld = 1'b0;
    e = q.pop_front();
    n_chk++;
    if (a !== e.a) begin
      n_fail++;
      $display("FAIL r0_rd got %h want %h", a, e.a);
    end
    n_chk++;
    if (pend_cnt !== '0) begin
      n_fail++;
      $display("FAIL r0_issue got %0d want 0", pend_cnt);
    end
  endtask

  task automatic test_forward();
    logic [1:0]    sa[5];
    logic [1:0]    sbv[5];
    logic          im[5];
    logic [DW-1:0] xa[5];
    logic [DW-1:0] xb[5];
    sa  = '{2'd2, 2'd3, 2'd3, 2'd1, 2'd0};
    sbv = '{2'd1, 2'd1, 2'd1, 2'd3, 2'd2};
    im  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    xa  = '{16'hD000, 16'hE000, 16'hE000,
            16'hC000, 16'h0000};
    xb  = '{16'hC000, 16'hC000, 16'hFFFF,
            16'hE000, 16'hD000};
    ra = 5'd0; rb = 5'd0;
    for (int i = 0; i < 5; i++) begin
      sel_a = sa[i]; sel_b = sbv[i]; imm_sel = im[i];
      q.push_back('{a: xa[i], b: xb[i]});
      step();
      e = q.pop_front();
      n_chk++;
      if (a !== e.a) begin
        n_fail++;
        $display("FAIL fwd%0d_a got %h want %h",
                 i, a, e.a);
      end
      n_chk++;
      if (b !== e.b) begin
        n_fail++;
        $display("FAIL fwd%0d_b got %h want %h",
                 i, b, e.b);
      end
    end
    sel_a = 2'b00; sel_b = 2'b00; imm_sel = 1'b0;
  endtask

  task automatic test_hazard();
    ra = 5'd7; rb = 5'd0;
    issue_vld = 1'b1; issue_rd = 5'd5;
    q.push_back('{a: 16'hABCD, b: 16'h0});
    step();
    e = q.pop_front();
    n_chk++;
    if (a !== e.a) begin
      n_fail++;
      $display("FAIL haz_issue got %h want %h", a, e.a);
    end
    issue_vld = 1'b0; ra = 5'd5;
    #1;
    n_chk++;
    if (hazard !== SB) begin
      n_fail++;
      $display("FAIL haz_set got %b want %b", hazard, SB);
    end
    n_chk++;
    if (pend_cnt !== (AW+1)'(SB)) begin
      n_fail++;
      $display("FAIL haz_cnt1 got %0d want %0d",
               pend_cnt, SB);
    end
    q.push_back('{a: SB ? 16'hABCD : 16'h0, b: 16'h0});
    step();
    e = q.pop_front();
    n_chk++;
    if (a !== e.a) begin
      n_fail++;
      $display("FAIL haz_hold got %h want %h", a, e.a);
    end
    we = 1'b1; rw = 5'd5; wdata = 16'h0055;
    #1;
    n_chk++;
    if (hazard !== 1'b0) begin
      n_fail++;
      $display("FAIL haz_byp got %b want 0", hazard);
    end
    q.push_back('{a: 16'h0055, b: 16'h0});
    step();
    we = 1'b0;
    e = q.pop_front();
    n_chk++;
    if (a !== e.a) begin
      n_fail++;
      $display("FAIL haz_wb got %h want %h", a, e.a);
    end
    n_chk++;
    if (pend_cnt !== '0) begin
      n_fail++;
      $display("FAIL haz_clr got %0d want 0", pend_cnt);
    end
  endtask

  task automatic test_set_clear();
    ra = 5'd0; rb = 5'd0;
    issue_vld = 1'b1; issue_rd = 5'd9;
    we = 1'b1; rw = 5'd9; wdata = 16'h0999;
    step();
    issue_vld = 1'b0; we = 1'b0;
    n_chk++;
    if (pend_cnt !== (AW+1)'(SB)) begin
      n_fail++;
      $display("FAIL sc_win got %0d want %0d",
               pend_cnt, SB);
    end
    rb = 5'd9; imm_sel = 1'b1;
    #1;
    n_chk++;
    if (hazard !== 1'b0) begin
      n_fail++;
      $display("FAIL sc_imm got %b want 0", hazard);
    end
    imm_sel = 1'b0;
    #1;
    n_chk++;
    if (hazard !== SB) begin
      n_fail++;
      $display("FAIL sc_rb got %b want %b", hazard, SB);
    end
    issue_vld = 1'b1; issue_rd = 5'd10;
    step();
    issue_vld = 1'b0;
    n_chk++;
    if (pend_cnt !== (AW+1)'(SB)) begin
      n_fail++;
      $display("FAIL sc_block got %0d want %0d",
               pend_cnt, SB);
    end
    we = 1'b1; rw = 5'd9; wdata = 16'h1999;
    q.push_back('{a: 16'h0, b: 16'h1999});
    step();
    we = 1'b0;
    e = q.pop_front();
    n_chk++;
    if (b !== e.b) begin
      n_fail++;
      $display("FAIL sc_b got %h want %h", b, e.b);
    end
    n_chk++;
    if (pend_cnt !== '0) begin
      n_fail++;
      $display("FAIL sc_clr got %0d want 0", pend_cnt);
    end
  endtask

  task automatic test_hold();
    hold = 1'b1;
    sel_a = 2'b01; imm_sel = 1'b1;
    issue_vld = 1'b1; issue_rd = 5'd12;
    step();
    step();
    n_chk++;
    if (a !== 16'h0 || b !== 16'h1999) begin
      n_fail++;
      $display("FAIL hold_ab got %h/%h want 0000/1999",
               a, b);
    end
    n_chk++;
    if (pend_cnt !== '0) begin
      n_fail++;
      $display("FAIL hold_iss got %0d want 0", pend_cnt);
    end
    hold = 1'b0; issue_vld = 1'b0;
    q.push_back('{a: 16'hC000, b: 16'hFFFF});
    step();
    e = q.pop_front();
    n_chk++;
    if (a !== e.a || b !== e.b) begin
      n_fail++;
      $display("FAIL hold_rel got %h/%h want %h/%h",
               a, b, e.a, e.b);
    end
  endtask

  task automatic test_reset_mid();
    we = 1'b1; rw = 5'd3; wdata = 16'h3333;
    issue_vld = 1'b1; issue_rd = 5'd4;
    step();
    we = 1'b0; issue_vld = 1'b0;
    n_chk++;
    if (pend_cnt !== (AW+1)'(SB)) begin
      n_fail++;
      $display("FAIL mid_pre got %0d want %0d",
               pend_cnt, SB);
    end
    #3 rst_n = 1'b0;
    #1;
    n_chk++;
    if (a !== 16'h0 || b !== 16'h0) begin
      n_fail++;
      $display("FAIL mid_ab got %h/%h want 0000/0000",
               a, b);
    end
    n_chk++;
    if (pend_cnt !== '0) begin
      n_fail++;
      $display("FAIL mid_cnt got %0d want 0", pend_cnt);
    end
    #2 rst_n = 1'b1;
    sel_a = 2'b00; sel_b = 2'b00; imm_sel = 1'b0;
    ra = 5'd3; rb = 5'd4;
    #1;
    n_chk++;
    if (hazard !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_haz got %b want 0", hazard);
    end
    q.push_back('{a: 16'h0, b: 16'h0});
    step();
    e = q.pop_front();
    n_chk++;
    if (a !== e.a || b !== e.b) begin
      n_fail++;
      $display("FAIL mid_rd got %h/%h want %h/%h",
               a, b, e.a, e.b);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_r0();
    test_forward();
    test_hazard();
    test_set_clear();
    test_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
